// File: rtl/seg7_pkg.sv
// Shared glyph table and output-polarity helpers for the multiplexed seven-segment driver.
package seg7_pkg;

  localparam int unsigned SEG_W = 8;

  typedef logic [6:0] glyph_t;

  // Active-high a..g pattern (a = bit 0) for a hex nibble; b and d are lower case.
  function automatic glyph_t hex_glyph(input logic [3:0] nib);
    glyph_t g;
    case (nib)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  function automatic logic [SEG_W-1:0] seg_polarity(input logic [SEG_W-1:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

  function automatic logic [SEG_W-1:0] seg_off(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

  function automatic logic sel_off(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Data-source side and pin side of the seven-segment scan driver.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank;
  logic                load;
  logic                lz_blank;
  logic [BRIGHT_W-1:0] bright;
  logic [SEG_W-1:0]    SEG;
  logic [DIGITS-1:0]   SEG_S;
  logic                frame_done;

  modport master (
    output data, dp, blank, load, lz_blank, bright,
    input  SEG, SEG_S, frame_done
  );

  modport slave (
    input  data, dp, blank, load, lz_blank, bright,
    output SEG, SEG_S, frame_done
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble + decimal point to active-high {dp,g..a} pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0]       nibble_i,
  input  logic             dp_i,
  output logic [SEG_W-1:0] pattern_o
);
  assign pattern_o = {dp_i, hex_glyph(nibble_i)};
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner: frame-synchronised double buffer, leading-zero
// suppression, per-digit blanking, PWM brightness and a dead cycle at each slot end.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input logic              clk,
  input logic              reset,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned TICK_DIV = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int unsigned PH_DIV   = TICK_DIV >> BRIGHT_W;
  localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DATA_W   = 4 * DIGITS;

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg7_scan_driver: DIGITS must be 1..8");
  end
  if (PH_DIV == 0 || (TICK_DIV % (2 ** BRIGHT_W)) != 0) begin : g_bad_tick
    $error("seg7_scan_driver: TICK_DIV must be a non-zero multiple of 2**BRIGHT_W");
  end

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]  pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]  pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [DIGITS-1:0]  sel_q, sel_d;
  logic               frame_done_q, frame_done_d;

  logic               presc_last, wrap;
  logic [BRIGHT_W-1:0] sub_phase;
  logic [DIGITS-1:0]  lz_mask, sel_on;
  logic [3:0]         cur_nib;
  logic               cur_dp, cur_blank, cur_lz, dark, en;
  logic [SEG_W-1:0]   dec_pat, seg_pat;

  // Digit i>0 is suppressed when it and every digit to its left hold zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      all_zero   = all_zero & (disp_data_q[4*i +: 4] == 4'h0);
      lz_mask[i] = bus.lz_blank & all_zero;
    end
  end

  // Current-digit mux in front of the single decoder.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    sel_on    = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_data_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = disp_blank_q[i];
        cur_lz    = lz_mask[i];
        sel_on[i] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i  (cur_nib),
    .dp_i      (cur_dp),
    .pattern_o (dec_pat)
  );

  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    frame_done_d = 1'b0;

    presc_last = (presc_q == PRESC_W'(TICK_DIV - 1));
    wrap       = presc_last && (idx_q == IDX_W'(DIGITS - 1));
    sub_phase  = BRIGHT_W'(presc_q / PRESC_W'(PH_DIV));

    presc_d = presc_last ? '0 : presc_q + PRESC_W'(1);
    if (presc_last) begin
      idx_d = wrap ? '0 : idx_q + IDX_W'(1);
    end

    if (bus.load) begin
      pend_data_d  = bus.data;
      pend_dp_d    = bus.dp;
      pend_blank_d = bus.blank;
    end

    // Display takes the pending value from before this edge; a same-cycle load waits a frame.
    if (wrap) begin
      disp_data_d  = pend_data_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
      frame_done_d = 1'b1;
    end

    // A suppressed digit without dp has nothing to light, so it is not enabled either.
    dark    = cur_blank | (cur_lz & ~cur_dp);
    seg_pat = dec_pat;
    if (cur_lz) begin
      seg_pat[6:0] = '0;
    end
    if (cur_blank) begin
      seg_pat = '0;
    end
    en    = ~dark && (sub_phase <= bus.bright) && !presc_last;
    seg_d = seg_polarity(seg_pat, SEG_ACTIVE_LOW);
    sel_d = (en ? sel_on : '0) ^ {DIGITS{sel_off(SEL_ACTIVE_LOW)}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= seg_off(SEG_ACTIVE_LOW);
      sel_q        <= {DIGITS{sel_off(SEL_ACTIVE_LOW)}};
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.SEG        = seg_q;
  assign bus.SEG_S      = sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 16-cycle slots, active-low outputs.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned BRIGHT_W = 4;
  localparam int          SLOT     = 16;
  localparam int          FRAME    = 64;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [7:0] seg_rec [FRAME];
  logic [3:0] sel_rec [FRAME];

  seg7_scan_driver_if #(.DIGITS(DIGITS), .BRIGHT_W(BRIGHT_W)) bus ();

  seg7_scan_driver #(
    .DIGITS         (DIGITS),
    .CLK_HZ         (6400),
    .SCAN_HZ        (100),
    .BRIGHT_W       (BRIGHT_W),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bus.data  = d;
    bus.dp    = p;
    bus.blank = b;
    bus.load  = 1'b1;
    @(negedge clk);
    bus.load  = 1'b0;
  endtask

  // Stops at the negedge of the frame_done cycle, the first cycle of a new frame.
  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("wait_frame_timeout", 32'(found), 32'd1);
  endtask

  // Cycles after reset release until the first frame_done pulse.
  task automatic first_frame(input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.frame_done === 1'b1) begin
        first = k;
        break;
      end
    end
    chk(tag, 32'(first), 32'd64);
  endtask

  // Record one full frame of outputs; entry k reflects digit k/16 at prescaler k%16.
  task automatic measure_frame();
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      seg_rec[k] = bus.SEG;
      sel_rec[k] = bus.SEG_S;
    end
  endtask

  function automatic int count_en(input int d);
    logic [3:0] on_pat;
    int n;
    on_pat    = 4'hF;
    on_pat[d] = 1'b0;
    n = 0;
    for (int p = 0; p < SLOT; p++) begin
      if (sel_rec[d*SLOT + p] == on_pat) n++;
    end
    return n;
  endfunction

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.data     = '0;
    bus.dp       = '0;
    bus.blank    = '0;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;
    bus.bright   = 4'd15;

    // 1: reset state and first frame boundary
    skip(3);
    chk("rst_seg", 32'(bus.SEG), 32'hFF);
    chk("rst_sel", 32'(bus.SEG_S), 32'hF);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    reset = 1'b0;
    first_frame("first_frame_done");

    // 2: load 1234 with dp on digit 0, full brightness
    do_load(16'h1234, 4'b0001, 4'b0000);
    wait_frame();
    measure_frame();
    chk("d0_seg_4dp", 32'(seg_rec[0]), 32'h19);
    chk("d0_en_cycles", 32'(count_en(0)), 32'd15);
    chk("d0_en_p14", 32'(sel_rec[14]), 32'hE);
    chk("d0_dead", 32'(sel_rec[15]), 32'hF);
    chk("d1_seg_3", 32'(seg_rec[16]), 32'hB0);
    chk("d3_seg_1", 32'(seg_rec[48]), 32'hF9);

    // 3: mid-frame load held until wrap; load on the wrap cycle lands a frame later
    skip(20);
    do_load(16'h5678, 4'b0000, 4'b0000);
    skip(30);
    chk("mid_load_held", 32'(bus.SEG), 32'hF9);
    wait_frame();
    measure_frame();
    chk("mid_load_d0_8", 32'(seg_rec[0]), 32'h80);
    chk("mid_load_d3_5", 32'(seg_rec[48]), 32'h92);
    skip(63);
    do_load(16'h9ABC, 4'b0000, 4'b0000);
    measure_frame();
    chk("wrap_load_not_yet", 32'(seg_rec[0]), 32'h80);
    measure_frame();
    chk("wrap_load_shown", 32'(seg_rec[0]), 32'hC6);

    // 4: leading-zero suppression
    bus.lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_frame();
    measure_frame();
    chk("lz_d3_en", 32'(count_en(3)), 32'd0);
    chk("lz_d2_en", 32'(count_en(2)), 32'd0);
    chk("lz_d3_seg", 32'(seg_rec[48]), 32'hFF);
    chk("lz_d1_en", 32'(count_en(1)), 32'd15);
    chk("lz_d1_seg", 32'(seg_rec[16]), 32'h92);
    chk("lz_d0_seg", 32'(seg_rec[0]), 32'hC0);
    do_load(16'h0000, 4'b0100, 4'b0000);
    wait_frame();
    measure_frame();
    chk("lz0_d0_en", 32'(count_en(0)), 32'd15);
    chk("lz0_d0_seg", 32'(seg_rec[0]), 32'hC0);
    chk("lz0_d1_en", 32'(count_en(1)), 32'd0);
    chk("lz0_d2_dp_en", 32'(count_en(2)), 32'd15);
    chk("lz0_d2_dp_seg", 32'(seg_rec[32]), 32'h7F);
    chk("lz0_d3_en", 32'(count_en(3)), 32'd0);

    // 5: brightness and blanking
    bus.lz_blank = 1'b0;
    bus.bright   = 4'd0;
    do_load(16'h1234, 4'b0000, 4'b0000);
    wait_frame();
    measure_frame();
    chk("br0_d0_en", 32'(count_en(0)), 32'd1);
    chk("br0_p0", 32'(sel_rec[0]), 32'hE);
    chk("br0_p1", 32'(sel_rec[1]), 32'hF);
    chk("br0_d3_en", 32'(count_en(3)), 32'd1);
    bus.bright = 4'd7;
    measure_frame();
    chk("br7_d1_en", 32'(count_en(1)), 32'd8);
    do_load(16'h1234, 4'b0000, 4'b0100);
    wait_frame();
    measure_frame();
    chk("blank_d2_en", 32'(count_en(2)), 32'd0);
    chk("blank_d2_seg", 32'(seg_rec[32]), 32'hFF);
    chk("blank_d1_en", 32'(count_en(1)), 32'd8);

    // 6: reset mid-scan at digit 2, prescaler 9
    skip(41);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", 32'(bus.SEG), 32'hFF);
    chk("mid_rst_sel", 32'(bus.SEG_S), 32'hF);
    chk("mid_rst_fd", 32'(bus.frame_done), 32'h0);
    reset = 1'b0;
    first_frame("mid_rst_frame_done");
    measure_frame();
    chk("cleared_d0_seg", 32'(seg_rec[0]), 32'hC0);
    chk("cleared_d0_en", 32'(count_en(0)), 32'd8);
    chk("cleared_d2_en", 32'(count_en(2)), 32'd8);
    chk("cleared_d2_seg", 32'(seg_rec[32]), 32'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
